// File: rtl/ospike_collector.sv
// Output-spike collector: stores one spike bit per address for two timesteps, then streams START/HEADER/SPIKE/DONE tokens.
// Build option OSPIKE_DUP_DROP_EN: rewrites of an already-written address are dropped and flag err.
module ospike_collector #(
  parameter int DEPTH_R        = 21,
  parameter int WIDTH_PACKAGE  = 33,
  parameter int WIDTH_out_data = 13,
  parameter int LAYER_ID       = 1,
  parameter int PE_ID          = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pkt_valid,
  input  logic [WIDTH_PACKAGE-1:0]  pkt_data,
  output logic                      pkt_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_kind,
  output logic [1:0]                out_ts,
  output logic [1:0]                out_layer,
  output logic [11:0]               out_addr,
  output logic [WIDTH_out_data-1:0] out_data,
  output logic                      err
);

  localparam int         N    = DEPTH_R * DEPTH_R;
  localparam logic [8:0] FULL = 9'(N);
  localparam logic [8:0] LAST = 9'(N - 1);

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_HDR   = 2'd1;
  localparam logic [1:0] K_SPIKE = 2'd2;
  localparam logic [1:0] K_DONE  = 2'd3;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_START,
    S_HDR1,
    S_STR1,
    S_HDR2,
    S_STR2,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [N-1:0] map_1, map_2;
  logic [N-1:0] wr_1, wr_2;
  logic [8:0]   cnt_1, cnt_2;
  logic [8:0]   idx;
  logic         rdy_q;

  logic [3:0] f_dest;
  logic [1:0] f_type;
  logic [1:0] f_ts;
  logic [8:0] f_addr;
  logic       f_spike;

  assign f_dest  = pkt_data[32:29];
  assign f_type  = pkt_data[24:23];
  assign f_ts    = pkt_data[22:21];
  assign f_addr  = pkt_data[20:12];
  assign f_spike = pkt_data[0];

  logic unused_fields;
  assign unused_fields = ^{pkt_data[28:25], pkt_data[11:1]};

  logic accept, pkt_ok, sel2, hit_wr, do_write, drop, clear, ts2_full;

  assign pkt_ready = rdy_q && (state != S_DONE);
  assign accept    = pkt_valid && pkt_ready;
  assign pkt_ok    = (f_dest == 4'(PE_ID)) && (f_type == 2'b10) &&
                     ((f_ts == 2'd1) || (f_ts == 2'd2)) && (f_addr < FULL);
  assign sel2      = (f_ts == 2'd2);
  assign hit_wr    = sel2 ? wr_2[f_addr] : wr_1[f_addr];

`ifdef OSPIKE_DUP_DROP_EN
  assign do_write  = accept && pkt_ok && !hit_wr;
  assign drop      = accept && (!pkt_ok || hit_wr);
`else
  assign do_write  = accept && pkt_ok;
  assign drop      = accept && !pkt_ok;
`endif

  // DONE handshake wipes both timesteps so the next run starts empty.
  assign clear    = (state == S_DONE) && out_ready;
  assign ts2_full = (cnt_2 == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_1 <= '0;
      map_2 <= '0;
      wr_1  <= '0;
      wr_2  <= '0;
      cnt_1 <= '0;
      cnt_2 <= '0;
    end else if (clear) begin
      map_1 <= '0;
      map_2 <= '0;
      wr_1  <= '0;
      wr_2  <= '0;
      cnt_1 <= '0;
      cnt_2 <= '0;
    end else if (do_write) begin
      if (sel2) begin
        map_2[f_addr] <= f_spike;
        if (!hit_wr) begin
          wr_2[f_addr] <= 1'b1;
          cnt_2        <= cnt_2 + 9'd1;
        end
      end else begin
        map_1[f_addr] <= f_spike;
        if (!hit_wr) begin
          wr_1[f_addr] <= 1'b1;
          cnt_1        <= cnt_1 + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (((state == S_STR1) || (state == S_STR2)) && out_ready) begin
      idx <= (idx == LAST) ? 9'd0 : idx + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_COLLECT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    out_kind  = K_START;
    out_ts    = 2'd0;
    out_layer = 2'd0;
    out_addr  = 12'd0;
    out_data  = '0;
    case (state)
      S_COLLECT: begin
        if (cnt_1 == FULL) state_nx = S_START;
      end
      S_START: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_HDR1;
      end
      S_HDR1: begin
        out_valid = 1'b1;
        out_kind  = K_HDR;
        out_ts    = 2'd1;
        out_layer = 2'(LAYER_ID);
        if (out_ready) state_nx = S_STR1;
      end
      S_STR1: begin
        out_valid   = 1'b1;
        out_kind    = K_SPIKE;
        out_addr    = {3'b000, idx};
        out_data[0] = map_1[idx];
        if (out_ready && (idx == LAST)) state_nx = S_HDR2;
      end
      S_HDR2: begin
        // Timestep 2 may still be filling; hold the header back until it is complete.
        out_valid = ts2_full;
        out_kind  = K_HDR;
        out_ts    = 2'd2;
        out_layer = 2'(LAYER_ID);
        if (ts2_full && out_ready) state_nx = S_STR2;
      end
      S_STR2: begin
        out_valid   = 1'b1;
        out_kind    = K_SPIKE;
        out_addr    = {3'b000, idx};
        out_data[0] = map_2[idx];
        if (out_ready && (idx == LAST)) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_kind  = K_DONE;
        if (out_ready) state_nx = S_COLLECT;
      end
      default: state_nx = S_COLLECT;
    endcase
  end

endmodule

// File: tb/tb_ospike_collector.sv
// Directed bench for ospike_collector: full runs, stalls, invalid/duplicate packets, HDR2 wait and mid-stream reset.
`timescale 1ns/1ps
module tb_ospike_collector;
  localparam int N = 441;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic [32:0] pkt_data = '0;
  logic        out_ready = 1'b0;
  logic        pkt_ready, out_valid, err;
  logic [1:0]  out_kind, out_ts, out_layer;
  logic [11:0] out_addr;
  logic [12:0] out_data;

  int tests = 0;
  int fails = 0;

  bit exp_map1[N];
  bit exp_map2[N];
  bit exp_wr1[N];
  bit exp_wr2[N];
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  ospike_collector dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_ts(out_ts), .out_layer(out_layer),
    .out_addr(out_addr), .out_data(out_data), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      exp_map1[i] = 1'b0; exp_map2[i] = 1'b0;
      exp_wr1[i]  = 1'b0; exp_wr2[i]  = 1'b0;
    end
  endtask

  function automatic logic spike_of(input int p, input int a);
    case (p)
      0:       return a[0];
      1:       return a[1];
      2:       return ~a[0];
      default: return a[2];
    endcase
  endfunction

  task automatic send_pkt(input logic [3:0] dest, input logic [1:0] ts,
                          input logic [8:0] addr, input logic spike);
    int w;
    w = 0;
    pkt_valid = 1'b1;
    pkt_data  = {dest, 4'd3, 2'b10, ts, addr, 11'd0, spike};
    while (!pkt_ready && w < 10) begin
      tick();
      w++;
    end
    if (w == 10) begin
      tests++; fails++;
      $display("FAIL pkt_ready_timeout: pkt_ready=%b required 1", pkt_ready);
    end
    tick();
    pkt_valid = 1'b0;
    if (dest == 4'd12 && (ts == 2'd1 || ts == 2'd2) && addr < 9'd441) begin
      if (ts == 2'd1) begin
        if (!exp_wr1[addr]) begin exp_wr1[addr] = 1'b1; exp_map1[addr] = spike; end
`ifdef OSPIKE_DUP_DROP_EN
        else exp_err = 1'b1;
`else
        else exp_map1[addr] = spike;
`endif
      end else begin
        if (!exp_wr2[addr]) begin exp_wr2[addr] = 1'b1; exp_map2[addr] = spike; end
`ifdef OSPIKE_DUP_DROP_EN
        else exp_err = 1'b1;
`else
        else exp_map2[addr] = spike;
`endif
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic write_ts(input logic [1:0] ts, input int pattern, input bit reverse, input int count);
    for (int j = 0; j < count; j++) begin
      int a;
      a = reverse ? (N - 1 - j) : j;
      send_pkt(4'd12, ts, 9'(a), spike_of(pattern, a));
    end
  endtask

  // Token k of a run: 0 START, 1 HDR ts1, 2..442 SPIKE map1, 443 HDR ts2, 444..884 SPIKE map2, 885 DONE.
  function automatic logic [31:0] exp_tok(input int k);
    if (k == 0)   return {1'b1, 2'd0, 29'd0};
    if (k == 1)   return {1'b1, 2'd1, 2'd1, 2'd1, 25'd0};
    if (k < 443)  return {1'b1, 2'd2, 4'd0, 12'(k - 2), 12'd0, exp_map1[k - 2]};
    if (k == 443) return {1'b1, 2'd1, 2'd2, 2'd1, 25'd0};
    if (k < 885)  return {1'b1, 2'd2, 4'd0, 12'(k - 444), 12'd0, exp_map2[k - 444]};
    return {1'b1, 2'd3, 29'd0};
  endfunction

  task automatic consume(input int k_start, input int k_end, input bit toggle, output int cycles);
    int k;
    int cyc;
    logic [31:0] obs, expv;
    logic hs;
    k = k_start;
    cyc = 0;
    while (k < k_end && cyc < 4000) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      expv = exp_tok(k);
      case (expv[30:29])
        2'd1:    obs = {out_valid, out_kind, out_ts, out_layer, 25'd0};
        2'd2:    obs = {out_valid, out_kind, 4'd0, out_addr, out_data};
        default: obs = {out_valid, out_kind, 29'd0};
      endcase
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL stream_token k=%0d cyc=%0d: got %h required %h", k, cyc, obs, expv);
      end
      hs = out_valid & out_ready;
      tick();
      cyc++;
      if (hs) k++;
    end
    out_ready = 1'b0;
    if (k < k_end) begin
      tests++; fails++;
      $display("FAIL stream_timeout: reached token %0d required %0d", k, k_end);
    end
    cycles = cyc;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (pkt_ready !== 1'b0) begin fails++; $display("FAIL reset_pkt_ready: got %b required 0", pkt_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b required 0", err); end
    tests++;
    if ({out_kind, out_ts, out_layer, out_addr, out_data} !== 31'd0) begin
      fails++;
      $display("FAIL reset_out_fields: got %h required 0", {out_kind, out_ts, out_layer, out_addr, out_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++; if (pkt_ready !== 1'b1) begin fails++; $display("FAIL release_pkt_ready: got %b required 1", pkt_ready); end
  endtask

  task automatic test_full_run();
    int cyc;
    clear_model();
    out_ready = 1'b0;
    write_ts(2'd2, 0, 1'b0, N);
    write_ts(2'd1, 0, 1'b0, N - 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_440_valid: got %b required 0", out_valid); end
    send_pkt(4'd12, 2'd1, 9'd440, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_start_early: got %b required 0", out_valid); end
    tick();
    tests++; if ({out_valid, out_kind} !== 3'b100) begin fails++; $display("FAIL full_start_rise: got %b required 100", {out_valid, out_kind}); end
    consume(0, 886, 1'b0, cyc);
    tests++; if (cyc != 886) begin fails++; $display("FAIL full_cycles: got %0d required 886", cyc); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL full_err: got %b required 0", err); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_after_done: got %b required 0", out_valid); end
  endtask

  task automatic test_reverse_toggle();
    int cyc;
    clear_model();
    out_ready = 1'b0;
    write_ts(2'd2, 2, 1'b0, N);
    write_ts(2'd1, 1, 1'b1, N);
    tick();
    consume(0, 886, 1'b1, cyc);
    tests++; if (cyc != 1771) begin fails++; $display("FAIL toggle_cycles: got %0d required 1771", cyc); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL toggle_err: got %b required 0", err); end
  endtask

  task automatic test_rewrite();
    int cyc;
    logic want7, want_err;
`ifdef OSPIKE_DUP_DROP_EN
    want7 = 1'b1; want_err = 1'b1;
`else
    want7 = 1'b0; want_err = 1'b0;
`endif
    clear_model();
    out_ready = 1'b0;
    write_ts(2'd2, 0, 1'b0, N);
    send_pkt(4'd12, 2'd1, 9'd7, 1'b1);
    send_pkt(4'd12, 2'd1, 9'd7, 1'b0);
    tests++; if (err !== want_err) begin fails++; $display("FAIL rewrite_err: got %b required %b", err, want_err); end
    for (int a = 0; a < N; a++) begin
      if (a != 7) send_pkt(4'd12, 2'd1, 9'(a), spike_of(0, a));
    end
    tick();
    consume(0, 9, 1'b0, cyc);
    tests++;
    if ({out_addr, out_data} !== {12'd7, 12'd0, want7}) begin
      fails++;
      $display("FAIL rewrite_addr7: got addr %0d data %0d required addr 7 data %0d", out_addr, out_data, want7);
    end
    consume(9, 886, 1'b0, cyc);
    tests++; if (err !== want_err) begin fails++; $display("FAIL rewrite_err_end: got %b required %b", err, want_err); end
  endtask

  task automatic test_hdr2_wait();
    int cyc;
    clear_model();
    out_ready = 1'b0;
    write_ts(2'd1, 3, 1'b0, N);
    write_ts(2'd2, 1, 1'b0, N - 1);
    tick();
    consume(0, 443, 1'b0, cyc);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hdr2_hold_%0d: got %b required 0", i, out_valid); end
      tick();
    end
    out_ready = 1'b0;
    send_pkt(4'd12, 2'd2, 9'd440, spike_of(1, 440));
    tests++;
    if ({out_valid, out_kind, out_ts} !== 5'b10110) begin
      fails++;
      $display("FAIL hdr2_release: got %b required 10110", {out_valid, out_kind, out_ts});
    end
    consume(443, 886, 1'b0, cyc);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hdr2_after_done: got %b required 0", out_valid); end
  endtask

  task automatic test_invalid();
    clear_model();
    out_ready = 1'b0;
    send_pkt(4'd12, 2'd1, 9'd441, 1'b1);
    send_pkt(4'd12, 2'd3, 9'd440, 1'b1);
    send_pkt(4'd5,  2'd1, 9'd440, 1'b1);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL invalid_err: got %b required 1", err); end
    write_ts(2'd1, 0, 1'b0, N - 1);
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL invalid_count: got out_valid %b required 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int cyc;
    send_pkt(4'd12, 2'd1, 9'd440, spike_of(0, 440));
    write_ts(2'd2, 0, 1'b0, N);
    tick();
    consume(0, 202, 1'b0, cyc);
    tests++; if (out_addr !== 12'd200) begin fails++; $display("FAIL midrst_addr: got %0d required 200", out_addr); end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({pkt_ready, out_valid, out_kind, out_ts, out_layer, out_addr, out_data, err} !== 34'd0) begin
      fails++;
      $display("FAIL midrst_outputs: got %h required 0",
               {pkt_ready, out_valid, out_kind, out_ts, out_layer, out_addr, out_data, err});
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_cleared: got out_valid %b required 0", out_valid); end
    clear_model();
    exp_err = 1'b0;
    write_ts(2'd2, 3, 1'b0, N);
    write_ts(2'd1, 2, 1'b0, N);
    tick();
    consume(0, 886, 1'b0, cyc);
    tests++; if (cyc != 886) begin fails++; $display("FAIL midrst_rerun_cycles: got %0d required 886", cyc); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_rerun_err: got %b required 0", err); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_reverse_toggle();
    test_rewrite();
    test_hdr2_wait();
    test_invalid();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ospike_collector.md
# ospike_collector

Clocked output-spike collector between the NoC router port for PE 12 (output memory) and the testbench-facing result channels. It accepts 33-bit spike packets from the pooling PEs and stores one spike bit per output address for each of the two timesteps. When a timestep's 21×21 map is complete, it streams the map in address order as a START / HEADER / SPIKE... / DONE token sequence. This matches the order in which the control bench consumes `start_r`, `ts_r`, `layer_r`, `out_spike_addr`/`out_spike_data` and `done_r`.

## Interface
- `DEPTH_R`, 21: output map side; map holds DEPTH_R*DEPTH_R = 441 entries.
- `WIDTH_PACKAGE`, 33: NoC packet width.
- `WIDTH_out_data`, 13: output data width.
- `LAYER_ID`, 1: value reported in HEADER tokens.
- `PE_ID`, 12: expected destination field.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: inbound packet valid.
- `pkt_data` in 33: fields are [32:29] dest, [28:25] src, [24:23] type, [22:21] timestep, [20:12] addr, [0] spike.
- `pkt_ready` out 1: collector accepts the packet.
- `out_valid` out 1: output token valid.
- `out_ready` in 1: consumer accepts the token.
- `out_kind` out 2: 0 START, 1 HEADER, 2 SPIKE, 3 DONE.
- `out_ts` out 2: timestep (HEADER).
- `out_layer` out 2: LAYER_ID (HEADER).
- `out_addr` out 12: spike address (SPIKE).
- `out_data` out 13: {12'b0, spike bit} (SPIKE).
- `err` out 1: sticky; set on any dropped packet.

## Operation
- A packet is accepted on a cycle with `pkt_valid & pkt_ready`.
- A packet is valid only when all of these hold:
  - dest == PE_ID
  - type == 2'b10
  - timestep ∈ {1, 2}
  - addr < 441
- Invalid packets are consumed, dropped, and set `err`.
- Storage per timestep t:
  - `map_t[441]`: spike bits.
  - `wr_t[441]`: written flags.
  - `cnt_t`: 9-bit count of set `wr_t` flags.
- Write handling:
  - A first write to an address sets `wr_t[addr]` and increments `cnt_t`.
  - A rewrite does not change `cnt_t`; see Configuration for how `map_t` is handled.
- Timestep t is complete when `cnt_t == 441`. Packets for a timestep keep being accepted while the other timestep is streaming.
- FSM states and transitions:
  - COLLECT → START when `cnt_1 == 441`.
  - START (kind 0) → HDR1 on handshake.
  - HDR1 (kind 1, ts = 1) → STR1 on handshake.
  - STR1 (kind 2) emits addr 0..440 from `map_1`. The index advances per handshake. → HDR2 after addr 440 handshakes.
  - HDR2 waits for `cnt_2 == 441`, then presents kind 1 with ts = 2. → STR2 on handshake.
  - STR2 (kind 2) emits addr 0..440 from `map_2`. → DONE after addr 440 handshakes.
  - DONE (kind 3) → COLLECT on handshake. On that transition all maps, flags, counts and the stream index clear; `err` is kept.
- `out_valid` is 0 in COLLECT and in HDR2 while `cnt_2 < 441`; it is 1 in every other state.
- `pkt_ready` is 1 in all states except DONE.

## Timing
- Reset values:
  - `pkt_ready` 0 during reset, 1 from the first clock after release.
  - `out_valid` 0, `out_kind` 0, `out_ts` 0, `out_layer` 0, `out_addr` 0, `out_data` 0, `err` 0.
  - State COLLECT; storage cleared.
- Latency:
  - A write is visible in `map_t` on the next edge.
  - START's `out_valid` rises one cycle after the edge that brings `cnt_1` to 441.
- Handshake:
  - Outputs hold stable while `out_valid & !out_ready`.
  - With `out_ready` tied high, one SPIKE token issues per cycle. A full run is therefore 1 + 1 + 441 + 1 + 441 + 1 = 886 handshake cycles minimum.
- Simultaneous events: a packet writing `map_2` in the same cycle that STR1 emits is legal; the two maps are independent.
- Reset asserted mid-stream: immediate return to the reset values. Partial maps are discarded.

## Configuration
- `OSPIKE_DUP_DROP_EN` defined: a packet whose `wr_t[addr]` is already set is dropped (`map_t` unchanged) and sets `err`.
- Undefined: the rewrite overwrites `map_t[addr]` silently and `err` is not set.
- Count behaviour is identical in both builds.

## Test plan
- Write all 441 ts1 and 441 ts2 addresses in order with spike = addr[0], `out_ready` = 1. Expect START, HDR (1, 1), 441 SPIKE with `out_data` = addr[0], HDR (2, 1), 441 SPIKE, DONE, in 886 cycles; `err` = 0.
- Write ts1 in reverse order while `out_ready` toggles 1/0 every cycle. Expect identical in-order tokens and data held stable during stalls.
- Send a packet with addr 441, then one with timestep 3, then one with dest 5. Expect all dropped, `err` = 1, counts unchanged.
- Write ts1 addr 7 spike = 1, then rewrite addr 7 spike = 0 before the set is complete.
  - With `OSPIKE_DUP_DROP_EN`: SPIKE addr 7 data = 1, `err` = 1.
  - Without: data = 0, `err` = 0.
- Complete ts1, hold ts2 at 440 writes. Expect STR1 to finish and HDR2 to keep `out_valid` = 0. The 441st ts2 write raises `out_valid` on the next cycle.
- Assert `rst_n` = 0 at SPIKE addr 200 of STR1. Expect all outputs at reset values. A fresh full run afterwards produces a correct sequence.
